// File: rtl/alu_seq_console.sv
// alu_seq_console: debounced single-button A/B/opcode entry console driving a registered ALU onto the LEDs
module alu_seq_console #(
  parameter int SIZEDATA   = 8,
  parameter int SIZEOP     = 6,
  parameter int DEB_CYCLES = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [SIZEDATA-1:0] SWITCHES,
  input  logic                BTN_LOAD,
  input  logic                BTN_CLEAR,
  output logic [SIZEDATA-1:0] LEDS,
  output logic                C_LED,
  output logic                V_LED,
  output logic                Z_LED,
  output logic                ERR_LED,
  output logic [1:0]          STATE_LEDS,
  output logic                RESULT_VALID
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int M = SIZEDATA - 1;
  localparam logic [SIZEOP-1:0] OP_ADD = SIZEOP'(6'b100000);
  localparam logic [SIZEOP-1:0] OP_SUB = SIZEOP'(6'b100010);
  localparam logic [SIZEOP-1:0] OP_AND = SIZEOP'(6'b100100);
  localparam logic [SIZEOP-1:0] OP_OR  = SIZEOP'(6'b100101);
  localparam logic [SIZEOP-1:0] OP_XOR = SIZEOP'(6'b100110);
  localparam logic [SIZEOP-1:0] OP_NOR = SIZEOP'(6'b100111);
  localparam logic [SIZEOP-1:0] OP_SRA = SIZEOP'(6'b000011);
  localparam logic [SIZEOP-1:0] OP_SRL = SIZEOP'(6'b000010);
  typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_RES} state_t;
  logic [1:0] raw, pulse;
  assign raw = {BTN_CLEAR, BTN_LOAD};
  // Level is accepted only after DEB_CYCLES consecutive disagreeing samples; pulse fires on accepted rise
  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic s1_q, s2_q, deb_q, pulse_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge CLK) begin
      if (RESET) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
        deb_q <= 1'b0;
        pulse_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q <= raw[g];
        s2_q <= s1_q;
        pulse_q <= 1'b0;
        if (s2_q == deb_q) cnt_q <= '0;
        else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
          deb_q <= s2_q;
          pulse_q <= s2_q;
          cnt_q <= '0;
        end else cnt_q <= cnt_q + 1'b1;
      end
    end
    assign pulse[g] = pulse_q;
  end
  logic ld, clr;
  assign ld = pulse[0];
  assign clr = pulse[1];
  state_t state_q, state_d;
  logic [SIZEDATA-1:0] a_q, a_d, b_q, b_d, res_q, res_d, alu_r;
  logic [SIZEOP-1:0] op_q, op_d;
  logic c_q, c_d, v_q, v_d, z_q, z_d, err_q, err_d, alu_c, alu_v, alu_err, big;
  logic [SIZEDATA:0] sum, dif;
  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q};
    dif = {1'b0, a_q} - {1'b0, b_q};
    big = b_q >= SIZEDATA'(SIZEDATA);
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_r = sum[M:0];
        alu_c = sum[SIZEDATA];
        alu_v = (a_q[M] == b_q[M]) && (sum[M] != a_q[M]);
      end
      OP_SUB: begin
        alu_r = dif[M:0];
        alu_c = dif[SIZEDATA];
        alu_v = (a_q[M] != b_q[M]) && (dif[M] != a_q[M]);
      end
      OP_AND: alu_r = a_q & b_q;
      OP_OR:  alu_r = a_q | b_q;
      OP_XOR: alu_r = a_q ^ b_q;
      OP_NOR: alu_r = ~(a_q | b_q);
      OP_SRA: alu_r = big ? {SIZEDATA{a_q[M]}} : $unsigned($signed(a_q) >>> b_q);
      OP_SRL: alu_r = big ? '0 : a_q >> b_q;
      default: alu_err = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    res_d = res_q;
    c_d = c_q;
    v_d = v_q;
    z_d = z_q;
    err_d = err_q;
    if (clr) begin
      state_d = S_A;
      a_d = '0;
      b_d = '0;
      op_d = '0;
      res_d = '0;
      c_d = 1'b0;
      v_d = 1'b0;
      z_d = 1'b0;
      err_d = 1'b0;
    end else begin
      case (state_q)
        S_A, S_RES: if (ld) begin
          a_d = SWITCHES;
          state_d = S_B;
        end
        S_B: if (ld) begin
          b_d = SWITCHES;
          state_d = S_OP;
        end
        S_OP: if (ld) begin
          op_d = SWITCHES[SIZEOP-1:0];
          state_d = S_EXEC;
        end
        S_EXEC: begin
          res_d = alu_r;
          c_d = alu_c;
          v_d = alu_v;
          z_d = ~|alu_r;
          err_d = alu_err;
          state_d = S_RES;
        end
        default: state_d = S_A;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_A;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res_q <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      res_q <= res_d;
      c_q <= c_d;
      v_q <= v_d;
      z_q <= z_d;
      err_q <= err_d;
    end
  end
  assign LEDS = res_q;
  assign C_LED = c_q;
  assign V_LED = v_q;
  assign Z_LED = z_q;
  assign ERR_LED = err_q;
  assign RESULT_VALID = state_q == S_RES;
  assign STATE_LEDS = (state_q == S_A) ? 2'b00 : (state_q == S_B) ? 2'b01 : (state_q == S_RES) ? 2'b11 : 2'b10;
endmodule

// File: tb/tb_alu_seq_console.sv
// tb_alu_seq_console: directed console walk-through with a scoreboard of expected ALU results
module tb_alu_seq_console;
  localparam int W = 8, DEB = 4;
  logic CLK = 1'b0, RESET = 1'b1, BTN_LOAD = 1'b0, BTN_CLEAR = 1'b0;
  logic [W-1:0] SWITCHES = '0, LEDS;
  logic C_LED, V_LED, Z_LED, ERR_LED, RESULT_VALID;
  logic [1:0] STATE_LEDS;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic [W-1:0] r; logic c, v, z, e;} exp_t;
  exp_t sb[$];
  always #5 CLK = ~CLK;
  alu_seq_console #(.SIZEDATA(W), .SIZEOP(6), .DEB_CYCLES(DEB)) dut (
    .CLK(CLK), .RESET(RESET), .SWITCHES(SWITCHES), .BTN_LOAD(BTN_LOAD), .BTN_CLEAR(BTN_CLEAR),
    .LEDS(LEDS), .C_LED(C_LED), .V_LED(V_LED), .Z_LED(Z_LED), .ERR_LED(ERR_LED),
    .STATE_LEDS(STATE_LEDS), .RESULT_VALID(RESULT_VALID)
  );
  initial begin
    #1ms;
    $display("FAIL watchdog: run did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] op);
    exp_t e;
    logic [W:0] s;
    e = '0;
    case (op)
      6'b100000: begin
        s = {1'b0, a} + {1'b0, b};
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      6'b100010: begin
        e.r = a - b;
        e.c = a < b;
        e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      6'b100100: e.r = a & b;
      6'b100101: e.r = a | b;
      6'b100110: e.r = a ^ b;
      6'b100111: e.r = ~(a | b);
      6'b000011, 6'b000010: begin
        e.r = a;
        for (int k = 0; k < W && k < int'(b); k++) e.r = {op[0] & a[W-1], e.r[W-1:1]};
      end
      default: e.e = 1'b1;
    endcase
    e.z = e.r == '0;
    return e;
  endfunction
  task automatic press(input bit ld, input bit cl);
    for (int k = 0; k < 2; k++) begin
      BTN_LOAD = ld;
      BTN_CLEAR = cl;
      cyc(1);
      BTN_LOAD = 1'b0;
      BTN_CLEAR = 1'b0;
      cyc(1);
    end
    BTN_LOAD = ld;
    BTN_CLEAR = cl;
    cyc(DEB + 8);
    BTN_LOAD = 1'b0;
    BTN_CLEAR = 1'b0;
    cyc(DEB + 8);
  endtask
  task automatic load(input logic [W-1:0] v, input logic [1:0] st, input string tag);
    SWITCHES = v;
    press(1'b1, 1'b0);
    chk({tag, "_state"}, STATE_LEDS, st);
  endtask
  task automatic exec_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    exp_t e;
    int n;
    SWITCHES = {2'b00, op};
    sb.push_back(model(a, b, op));
    BTN_LOAD = 1'b1;
    n = 0;
    while (!RESULT_VALID && n < 60) begin
      cyc(1);
      n++;
    end
    chk({tag, "_latency"}, n, DEB + 4);
    cyc(4);
    BTN_LOAD = 1'b0;
    cyc(DEB + 8);
    e = sb.pop_front();
    chk({tag, "_leds"}, LEDS, e.r);
    chk({tag, "_c"}, C_LED, e.c);
    chk({tag, "_v"}, V_LED, e.v);
    chk({tag, "_z"}, Z_LED, e.z);
    chk({tag, "_err"}, ERR_LED, e.e);
    chk({tag, "_state"}, {STATE_LEDS, RESULT_VALID}, 3'b111);
  endtask
  initial begin
    BTN_LOAD = 1'b1;
    cyc(1);
    BTN_LOAD = 1'b0;
    BTN_CLEAR = 1'b1;
    cyc(1);
    RESET = 1'b0;
    BTN_CLEAR = 1'b0;
    chk("reset_outputs", {LEDS, C_LED, V_LED, Z_LED, ERR_LED, STATE_LEDS, RESULT_VALID}, '0);
    cyc(20);
    chk("reset_idle_state", STATE_LEDS, 2'b00);
    load(8'h7F, 2'b01, "add_a");
    load(8'h01, 2'b10, "add_b");
    exec_op(6'b100000, 8'h7F, 8'h01, "add");
    chk("add_literal", {LEDS, C_LED, V_LED, Z_LED}, {8'h80, 3'b010});
    load(8'h05, 2'b01, "sub_a");
    chk("res_hold_leds", LEDS, 8'h80);
    load(8'h07, 2'b10, "sub_b");
    exec_op(6'b100010, 8'h05, 8'h07, "sub");
    chk("sub_literal", {LEDS, C_LED, V_LED}, {8'hFE, 2'b10});
    load(8'h80, 2'b01, "sra_a");
    load(8'h03, 2'b10, "sra_b");
    exec_op(6'b000011, 8'h80, 8'h03, "sra");
    chk("sra_literal", LEDS, 8'hF0);
    load(8'h80, 2'b01, "srl_a");
    chk("res_hold_sra", LEDS, 8'hF0);
    load(8'h09, 2'b10, "srl_b");
    exec_op(6'b000010, 8'h80, 8'h09, "srl");
    chk("srl_literal", {LEDS, Z_LED}, {8'h00, 1'b1});
    load(8'h12, 2'b01, "undef_a");
    SWITCHES = 8'h34;
    for (int k = 0; k < 3; k++) begin
      BTN_LOAD = 1'b1;
      cyc(DEB - 1);
      BTN_LOAD = 1'b0;
      cyc(DEB + 4);
    end
    chk("glitch_no_advance", STATE_LEDS, 2'b01);
    BTN_LOAD = 1'b1;
    cyc(1000);
    chk("hold_one_advance", STATE_LEDS, 2'b10);
    BTN_LOAD = 1'b0;
    cyc(DEB + 8);
    chk("hold_release_state", STATE_LEDS, 2'b10);
    exec_op(6'b111111, 8'h12, 8'h34, "undef");
    chk("undef_literal", {LEDS, C_LED, V_LED, Z_LED, ERR_LED}, {8'h00, 4'b0011});
    load(8'hAA, 2'b01, "clr_a");
    load(8'h55, 2'b10, "clr_b");
    press(1'b0, 1'b1);
    chk("clear_outputs", {LEDS, C_LED, V_LED, Z_LED, ERR_LED, STATE_LEDS, RESULT_VALID}, '0);
    chk("clear_regs", {dut.a_q, dut.b_q, dut.op_q}, '0);
    SWITCHES = 8'h3C;
    press(1'b1, 1'b1);
    chk("clear_wins_state", STATE_LEDS, 2'b00);
    chk("clear_wins_a", dut.a_q, 8'h00);
    load(8'h77, 2'b01, "rst_a");
    RESET = 1'b1;
    cyc(1);
    RESET = 1'b0;
    chk("midreset_state", {STATE_LEDS, RESULT_VALID, LEDS}, '0);
    chk("midreset_a", dut.a_q, 8'h00);
    load(8'hC3, 2'b01, "and_a");
    load(8'hA5, 2'b10, "and_b");
    exec_op(6'b100100, 8'hC3, 8'hA5, "and");
    load(8'hC3, 2'b01, "or_a");
    load(8'hA5, 2'b10, "or_b");
    exec_op(6'b100101, 8'hC3, 8'hA5, "or");
    load(8'hC3, 2'b01, "xor_a");
    load(8'hA5, 2'b10, "xor_b");
    exec_op(6'b100110, 8'hC3, 8'hA5, "xor");
    load(8'hC3, 2'b01, "nor_a");
    load(8'hA5, 2'b10, "nor_b");
    exec_op(6'b100111, 8'hC3, 8'hA5, "nor");
    load(8'h80, 2'b01, "sub_v_a");
    load(8'h01, 2'b10, "sub_v_b");
    exec_op(6'b100010, 8'h80, 8'h01, "sub_v");
    load(8'hFF, 2'b01, "add_c_a");
    load(8'h01, 2'b10, "add_c_b");
    exec_op(6'b100000, 8'hFF, 8'h01, "add_c");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
